// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the MEM-stage access unit: MemtoReg writeback
//   select encodings, the access FSM state type, and small helper functions
//   used by the top level and the timeout counter.
package mem_access_unit_pkg;

   // MemtoReg encodings as driven by the EX/MEM register.
   // Encoding 3 is an alias for the ALU path.
   localparam logic [1:0] MEMTOREG_ALU  = 2'd0;
   localparam logic [1:0] MEMTOREG_MEM  = 2'd1;
   localparam logic [1:0] MEMTOREG_PC   = 2'd2;
   localparam logic [1:0] MEMTOREG_ALU2 = 2'd3;

   // Access FSM states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } mau_state_t;

   // Word accesses only: both low address bits must be zero.
   function automatic logic is_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

   // Width of the timeout counter. A disabled timeout (0) still gets a
   // one-bit counter so that no zero-width vector is ever declared.
   function automatic int ctr_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr
//   Counts cycles spent waiting for a bus acknowledge. The count is cleared
//   while the unit is not requesting, advances once per enabled cycle and
//   saturates at TIMEOUT instead of wrapping.
//   'expired' is combinational and is high during the TIMEOUT-th enabled
//   cycle, so the caller can abandon the request at the end of that cycle.
//   TIMEOUT = 0 disables expiry altogether.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high
//   clear    in   synchronous clear of the count
//   enable   in   count this cycle
//   expired  out  this is the last permitted wait cycle
module mem_timeout_ctr
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 15
)
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = ctr_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Count holds the number of completed wait cycles; clear has priority
   // over enable and the count stops at SAT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != SAT)) begin
         count <= count + 1'b1;
      end
   end

   // In wait cycle k the count is k-1, so reaching LAST marks cycle TIMEOUT.
   assign expired = (TIMEOUT > 0) && enable && (count >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage consumer of the EX/MEM register. A load or store becomes a
//   registered req/ack transaction on the data bus. The pipeline stays
//   stalled until the responder acknowledges or the wait times out. The
//   writeback value for MEM/WB is selected by MemtoReg.
//   Misaligned accesses never reach the bus. Both misaligned accesses and
//   timeouts raise a one-cycle fault pulse and record the faulting PC.
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   mem_read, mem_write   EX/MEM MemRead / MemWrite (write wins if both set)
//   mem_to_reg            writeback select: 0/3 ALU, 1 memory, 2 PC+4
//   alu_out               byte address of the access / ALU result
//   store_data            EX/MEM Databus2
//   pc_plus_4, pc         EX/MEM PC+4 and PC of the instruction
//   bus_req, bus_we       registered request and write strobe
//   bus_addr, bus_wdata   registered word address and store data
//   bus_ack, bus_rdata    one-cycle completion strobe and read data
//   stall                 combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   wb_data               value to MEM/WB Databus3
//   bus_err, misalign     one-cycle fault pulses
//   fault_pc              PC of the most recent faulting access
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_to_reg,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] pc_plus_4,
   input  logic [DATA_W-1:0] pc,
   output logic              bus_req,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              stall,
   output logic [DATA_W-1:0] wb_data,
   output logic              bus_err,
   output logic              misalign,
   output logic [DATA_W-1:0] fault_pc
);

   mau_state_t        state;
   mau_state_t        state_next;

   logic              access;
   logic              aligned;

   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_next;
   logic              req_next;
   logic              we_next;
   logic [DATA_W-1:0] addr_next;
   logic [DATA_W-1:0] wdata_next;
   logic              err_next;
   logic              mis_next;
   logic [DATA_W-1:0] fault_pc_next;

   logic              to_clear;
   logic              to_enable;
   logic              to_expired;

   assign access  = mem_read | mem_write;
   assign aligned = is_aligned(alu_out[1:0]);

   // The wait counter runs only while requesting. It is held clear in every
   // other state, so each new request starts counting from zero.
   assign to_enable = (state == S_REQ);
   assign to_clear  = (state != S_REQ);

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (to_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and next values of every registered output.
   // Bus fields hold their value unless a new request is launched. The fault
   // pulses default low, so they last exactly one cycle. An acknowledge
   // takes priority over a timeout in the same cycle. bus_ack is only
   // looked at in REQ, so stray or late strobes have no effect.
   always_comb begin
      state_next    = state;
      req_next      = bus_req;
      we_next       = bus_we;
      addr_next     = bus_addr;
      wdata_next    = bus_wdata;
      rdata_next    = rdata_q;
      fault_pc_next = fault_pc;
      err_next      = 1'b0;
      mis_next      = 1'b0;

      case (state)
         S_IDLE: begin
            if (access) begin
               if (aligned) begin
                  req_next   = 1'b1;
                  we_next    = mem_write;
                  addr_next  = {alu_out[DATA_W-1:2], 2'b00};
                  wdata_next = store_data;
                  state_next = S_REQ;
               end else begin
                  mis_next      = 1'b1;
                  fault_pc_next = pc;
                  state_next    = S_DONE;
               end
            end
         end

         S_REQ: begin
            if (bus_ack) begin
               req_next = 1'b0;
               if (!bus_we) begin
                  rdata_next = bus_rdata;
               end
               state_next = S_DONE;
            end else if (to_expired) begin
               req_next      = 1'b0;
               err_next      = 1'b1;
               fault_pc_next = pc;
               rdata_next    = '0;
               state_next    = S_DONE;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
         end

         default: begin
            req_next   = 1'b0;
            state_next = S_IDLE;
         end
      endcase
   end

   // Registered bus interface, fault reporting and captured read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_q   <= '0;
         bus_err   <= 1'b0;
         misalign  <= 1'b0;
         fault_pc  <= '0;
      end else begin
         bus_req   <= req_next;
         bus_we    <= we_next;
         bus_addr  <= addr_next;
         bus_wdata <= wdata_next;
         rdata_q   <= rdata_next;
         bus_err   <= err_next;
         misalign  <= mis_next;
         fault_pc  <= fault_pc_next;
      end
   end

   // Stall goes high in the same cycle an aligned access shows up in IDLE,
   // and it stays high for the whole request. Misaligned accesses never
   // stall. Reset forces it low even if the EX/MEM inputs still show an
   // access.
   assign stall = !reset &&
                  (((state == S_IDLE) && access && aligned) || (state == S_REQ));

   // Writeback select. Held at zero during reset like the other outputs.
   always_comb begin
      wb_data = alu_out;
      case (mem_to_reg)
         MEMTOREG_MEM: wb_data = rdata_q;
         MEMTOREG_PC:  wb_data = pc_plus_4;
         default:      wb_data = alu_out;
      endcase
      if (reset) begin
         wb_data = '0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit. Each stimulus cycle pushes its
//   hand-computed expected outputs into a queue. A monitor on the falling
//   edge pops one entry per cycle and compares it with the DUT.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_to_reg;
   logic [31:0] alu_out;
   logic [31:0] store_data;
   logic [31:0] pc_plus_4;
   logic [31:0] pc;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        stall;
   logic [31:0] wb_data;
   logic        bus_err;
   logic        misalign;
   logic [31:0] fault_pc;

   typedef struct {
      int          vec;
      logic        stall;
      logic        req;
      logic        err;
      logic        mis;
      logic        chk_bus;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wb;
      logic [31:0] wb;
      logic [31:0] fpc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vec_id    = 0;
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   mem_access_unit #(
      .DATA_W  (32),
      .TIMEOUT (15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .alu_out    (alu_out),
      .store_data (store_data),
      .pc_plus_4  (pc_plus_4),
      .pc         (pc),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata),
      .stall      (stall),
      .wb_data    (wb_data),
      .bus_err    (bus_err),
      .misalign   (misalign),
      .fault_pc   (fault_pc)
   );

   // 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic compareField(input string name, input int vec,
                               input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act !== req) begin
         $display("[TB] FAIL vec%0d %s: got %h, expected %h", vec, name, act, req);
      end else begin
         pass_cnt++;
      end
   endtask

   // Compare one cycle of DUT outputs with its expected record.
   task automatic checkOutput(input exp_t e);
      compareField("stall",    e.vec, {31'd0, stall},    {31'd0, e.stall});
      compareField("bus_req",  e.vec, {31'd0, bus_req},  {31'd0, e.req});
      compareField("bus_err",  e.vec, {31'd0, bus_err},  {31'd0, e.err});
      compareField("misalign", e.vec, {31'd0, misalign}, {31'd0, e.mis});
      compareField("fault_pc", e.vec, fault_pc, e.fpc);
      if (e.chk_bus) begin
         compareField("bus_we",    e.vec, {31'd0, bus_we}, {31'd0, e.we});
         compareField("bus_addr",  e.vec, bus_addr,  e.addr);
         compareField("bus_wdata", e.vec, bus_wdata, e.wdata);
      end
      if (e.chk_wb) begin
         compareField("wb_data", e.vec, wb_data, e.wb);
      end
   endtask

   // Queue the expectation for the cycle whose inputs are now applied,
   // then move to just after the next rising edge.
   task automatic applyStimulus(input logic e_stall, input logic e_req,
                                input logic e_err, input logic e_mis,
                                input logic chk_bus, input logic e_we,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic chk_wb, input logic [31:0] e_wb,
                                input logic [31:0] e_fpc);
      exp_t e;
      e.vec     = vec_id;
      e.stall   = e_stall;
      e.req     = e_req;
      e.err     = e_err;
      e.mis     = e_mis;
      e.chk_bus = chk_bus;
      e.we      = e_we;
      e.addr    = e_addr;
      e.wdata   = e_wdata;
      e.chk_wb  = chk_wb;
      e.wb      = e_wb;
      e.fpc     = e_fpc;
      exp_q.push_back(e);
      vec_id++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks the DUT on the falling edge, away from input changes.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checkOutput(mon_e);
      end
   end

   // Watchdog against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset      = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 2'd1;
      alu_out    = 32'h0;
      store_data = 32'h0;
      pc_plus_4  = 32'h0;
      pc         = 32'h0;
      bus_ack    = 1'b0;
      bus_rdata  = 32'h0;

      // Reset state: everything zero.
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0);
      reset = 1'b0;

      // Non-memory instructions: no stall, ALU path for MemtoReg 0 and 3.
      mem_to_reg = 2'd0; alu_out = 32'h55;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h55, 32'h0);
      mem_to_reg = 2'd3; alu_out = 32'h77;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h77, 32'h0);

      // Read 0x100, ack in the first REQ cycle.
      pc = 32'h0040_0000; mem_read = 1'b1; mem_to_reg = 2'd1;
      alu_out = 32'h100; store_data = 32'hAAAA_5555;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      applyStimulus(1, 1, 0, 0, 1, 0, 32'h100, 32'hAAAA_5555, 0, 32'h0, 32'h0);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 32'h0);

      // Write 0x204, ack on the 4th REQ cycle. Its ack data must not land in rdata_q.
      mem_read = 1'b0; mem_write = 1'b1; mem_to_reg = 2'd0;
      alu_out = 32'h204; store_data = 32'h1234_5678; pc = 32'h0040_0010;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         bus_ack   = (i == 3);
         bus_rdata = 32'hFFFF_FFFF;
         applyStimulus(1, 1, 0, 0, 1, 1, 32'h204, 32'h1234_5678, 0, 32'h0, 32'h0);
      end
      bus_ack = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h204, 32'h0);
      mem_write = 1'b0; mem_to_reg = 2'd1; alu_out = 32'h0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 32'h0);

      // Read with no ack: 15 REQ cycles, then timeout.
      mem_read = 1'b1; alu_out = 32'h300; pc = 32'h0040_0040; store_data = 32'h0;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1, 1, 0, 0, 1, 0, 32'h300, 32'h0, 0, 32'h0, 32'h0);
      end
      applyStimulus(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0040_0040);
      mem_read = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0040_0040);

      // Misaligned load 0x102: no request, no stall, misalign pulse.
      mem_read = 1'b1; alu_out = 32'h102; pc = 32'h0040_0050; mem_to_reg = 2'd1;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0040_0040);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0040_0050);
      mem_read = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0040_0050);

      // Read and write both set: a write is issued.
      mem_read = 1'b1; mem_write = 1'b1; alu_out = 32'h208;
      store_data = 32'hCAFE_F00D; pc = 32'h0040_0060; mem_to_reg = 2'd0;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0040_0050);
      bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
      applyStimulus(1, 1, 0, 0, 1, 1, 32'h208, 32'hCAFE_F00D, 0, 32'h0, 32'h0040_0050);
      bus_ack = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h208, 32'h0040_0050);

      // jal writeback of PC+4, with a stray ack in IDLE that must be ignored.
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 2'd2;
      pc_plus_4 = 32'h0040_0008; alu_out = 32'h1234;
      bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0040_0008, 32'h0040_0050);
      bus_ack = 1'b0; mem_to_reg = 2'd1;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0040_0050);

      // Reset in the middle of a request.
      mem_read = 1'b1; alu_out = 32'h500; pc = 32'h0040_0070; store_data = 32'h0;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0040_0050);
      applyStimulus(1, 1, 0, 0, 1, 0, 32'h500, 32'h0, 0, 32'h0, 32'h0040_0050);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0);
      reset = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0);
      bus_ack = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0);

      // A normal read after reset.
      mem_read = 1'b1; alu_out = 32'h600; pc = 32'h0040_0080;
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      applyStimulus(1, 1, 0, 0, 1, 0, 32'h600, 32'h0, 0, 32'h0, 32'h0);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0BAD_F00D, 32'h0);
      mem_read = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0BAD_F00D, 32'h0);

      // Let the monitor drain; a stuck queue counts as a failed check.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
